// File: rtl/koopa_sprite_renderer.sv
// Koopa walk-sheet sprite front end: scan-position box test, ROM addressing with
// mirroring, walk-cycle animation timer and a two-stage colour-keyed pixel pipeline.
module koopa_sprite_renderer #(
    parameter int unsigned SPR_W       = 23,
    parameter int unsigned SPR_H       = 40,
    parameter int unsigned NUM_FRAMES  = 3,
    parameter int unsigned ANIM_DIV    = 8,
    parameter logic [5:0]  TRANSPARENT = 6'b110011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic        walking,
    input  logic        facing_left,
    output logic [11:0] rom_addr,
    input  logic [5:0]  rom_rgb,
    output logic [5:0]  pix_rgb,
    output logic        pix_on
);

    localparam int unsigned FRAME_WORDS = SPR_W * SPR_H;
    localparam int unsigned FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int unsigned DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [9:0]    lx;
    logic [9:0]    ly;
    logic          lflip;
    logic [FW-1:0] frame;
    logic [DW-1:0] div_cnt;
    logic          s1_valid;

    logic [10:0]   h_end;
    logic [10:0]   v_end;
    logic          in_box;
    logic [9:0]    col;
    logic [9:0]    row;
    logic [9:0]    xcol;
    logic [11:0]   addr;

    always_comb begin
        // 11-bit bounds so a sprite hanging off the right/bottom edge clips instead of wrapping
        h_end  = {1'b0, lx} + 11'(SPR_W);
        v_end  = {1'b0, ly} + 11'(SPR_H);
        in_box = (hcount >= lx) && ({1'b0, hcount} < h_end) &&
                 (vcount >= ly) && ({1'b0, vcount} < v_end);
        col    = hcount - lx;
        row    = vcount - ly;
        xcol   = lflip ? (10'(SPR_W - 1) - col) : col;
        addr   = 12'(frame) * 12'(FRAME_WORDS) + 12'(row) * 12'(SPR_W) + 12'(xcol);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lx      <= '0;
            ly      <= '0;
            lflip   <= 1'b0;
            frame   <= '0;
            div_cnt <= '0;
        end else if (frame_tick) begin
            lx    <= pos_x;
            ly    <= pos_y;
            lflip <= facing_left;
            if (!walking) begin
                div_cnt <= '0;
                frame   <= '0;
            end else if (div_cnt == DW'(ANIM_DIV - 1)) begin
                div_cnt <= '0;
                frame   <= (frame == FW'(NUM_FRAMES - 1)) ? '0 : frame + FW'(1);
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            s1_valid <= 1'b0;
            pix_on   <= 1'b0;
            pix_rgb  <= '0;
        end else begin
            rom_addr <= in_box ? addr : '0;
            s1_valid <= in_box;
            if (s1_valid && (rom_rgb != TRANSPARENT)) begin
                pix_on  <= 1'b1;
                pix_rgb <= rom_rgb;
            end else begin
                pix_on  <= 1'b0;
                pix_rgb <= '0;
            end
        end
    end

endmodule

// File: tb/tb_koopa_sprite_renderer.sv
// Bench for koopa_sprite_renderer: ROM image in an array, directed addressing/animation
// cases plus a randomized run against a tick-counting reference model.
module tb_koopa_sprite_renderer;

    localparam int W    = 23;
    localparam int H    = 40;
    localparam int NF   = 3;
    localparam int DIV  = 8;
    localparam logic [5:0] TRANSP = 6'b110011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic [9:0]  hcount = '0;
    logic [9:0]  vcount = '0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic        walking = 1'b0;
    logic        facing_left = 1'b0;
    logic [11:0] rom_addr;
    logic [5:0]  rom_rgb;
    logic [5:0]  pix_rgb;
    logic        pix_on;

    logic [5:0]  rom_mem [4096];

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_lx = 0, m_ly = 0, m_flip = 0, m_steps = 0;
    int e1_addr = 0, e1_v = 0, e2_on = 0, e2_rgb = 0;
    int m_col, m_row, m_xcol, m_frame, m_in;

    koopa_sprite_renderer #(
        .SPR_W(W), .SPR_H(H), .NUM_FRAMES(NF), .ANIM_DIV(DIV), .TRANSPARENT(TRANSP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .hcount(hcount), .vcount(vcount), .pos_x(pos_x), .pos_y(pos_y),
        .walking(walking), .facing_left(facing_left),
        .rom_addr(rom_addr), .rom_rgb(rom_rgb), .pix_rgb(pix_rgb), .pix_on(pix_on)
    );

    assign rom_rgb = rom_mem[rom_addr];

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Frame index follows from consecutive walking ticks: steps/DIV mod NF.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lx = 0; m_ly = 0; m_flip = 0; m_steps = 0;
            e1_addr = 0; e1_v = 0; e2_on = 0; e2_rgb = 0;
        end else begin
            e2_on  = (e1_v != 0 && rom_mem[e1_addr] != TRANSP) ? 1 : 0;
            e2_rgb = e2_on ? int'(rom_mem[e1_addr]) : 0;
            m_in   = (int'(hcount) >= m_lx && int'(hcount) < m_lx + W &&
                      int'(vcount) >= m_ly && int'(vcount) < m_ly + H) ? 1 : 0;
            m_col   = int'(hcount) - m_lx;
            m_row   = int'(vcount) - m_ly;
            m_xcol  = m_flip ? (W - 1 - m_col) : m_col;
            m_frame = (m_steps / DIV) % NF;
            e1_addr = m_in ? (m_frame * W * H + m_row * W + m_xcol) : 0;
            e1_v    = m_in;
            if (frame_tick) begin
                m_lx = int'(pos_x); m_ly = int'(pos_y); m_flip = int'(facing_left);
                m_steps = walking ? m_steps + 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        check_eq("m.rom_addr", int'(rom_addr), e1_addr);
        check_eq("m.pix_on", int'(pix_on), e2_on);
        check_eq("m.pix_rgb", int'(pix_rgb), e2_rgb);
    end

    task automatic tick(input int px, input int py, input bit face, input bit walk);
        @(negedge clk);
        pos_x = 10'(px); pos_y = 10'(py); facing_left = face; walking = walk;
        hcount = 10'd1023; vcount = 10'd1023; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n, input bit walk);
        for (int i = 0; i < n; i++) tick(100, 50, 1'b0, walk);
    endtask

    task automatic scan_chk(input string tag, input int h, input int v,
                            input int exp_addr, input bit exp_in);
        int exp_on;
        exp_on = (exp_in && rom_mem[exp_addr] != TRANSP) ? 1 : 0;
        @(negedge clk);
        hcount = 10'(h); vcount = 10'(v);
        @(posedge clk);
        #1 check_eq({tag, ".addr"}, int'(rom_addr), exp_addr);
        @(negedge clk);
        hcount = 10'd1023; vcount = 10'd1023;
        @(posedge clk);
        #1 check_eq({tag, ".on"}, int'(pix_on), exp_on);
        check_eq({tag, ".rgb"}, int'(pix_rgb), exp_on ? int'(rom_mem[exp_addr]) : 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++)
            rom_mem[i] = ($urandom_range(0, 5) == 0) ? TRANSP : 6'($urandom_range(0, 63));
        rom_mem[0]   = 6'b000100;
        rom_mem[919] = TRANSP;
        rom_mem[13]  = 6'b001010;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        tick(100, 50, 1'b0, 1'b0);
        scan_chk("left_of_box", 99, 50, 0, 1'b0);
        scan_chk("origin", 100, 50, 0, 1'b1);
        scan_chk("last_pixel_transp", 122, 89, 919, 1'b1);
        scan_chk("below_box", 122, 90, 0, 1'b0);

        tick(100, 50, 1'b1, 1'b0);
        scan_chk("mirror", 100, 51, 45, 1'b1);

        ticks(8, 1'b1);
        scan_chk("frame1", 100, 50, 920, 1'b1);
        ticks(8, 1'b1);
        scan_chk("frame2", 100, 50, 1840, 1'b1);
        ticks(7, 1'b1);
        scan_chk("frame2_hold", 100, 50, 1840, 1'b1);
        ticks(1, 1'b1);
        scan_chk("frame_wrap", 100, 50, 0, 1'b1);
        ticks(8, 1'b1);
        ticks(1, 1'b0);
        scan_chk("walk_drop", 100, 50, 0, 1'b1);
        ticks(7, 1'b1);
        scan_chk("div_restart", 100, 50, 0, 1'b1);
        ticks(1, 1'b1);
        scan_chk("div_full", 100, 50, 920, 1'b1);

        tick(1010, 50, 1'b0, 1'b0);
        scan_chk("edge_first", 1010, 50, 0, 1'b1);
        scan_chk("edge_1023", 1023, 50, 13, 1'b1);
        scan_chk("no_wrap_0", 0, 50, 0, 1'b0);
        scan_chk("no_wrap_8", 8, 50, 0, 1'b0);

        @(negedge clk);
        pos_x = 10'd200;
        scan_chk("latched_x", 1015, 50, 5, 1'b1);
        tick(200, 50, 1'b0, 1'b0);
        scan_chk("moved_x", 200, 50, 0, 1'b1);
        scan_chk("old_spot", 1015, 50, 0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            frame_tick = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) begin
                pos_x = 10'($urandom_range(0, 1023));
                pos_y = 10'($urandom_range(0, 900));
            end
            walking     = ($urandom_range(0, 39) != 0);
            facing_left = 1'($urandom_range(0, 1));
            hcount = 10'(m_lx + int'($urandom_range(0, 30)) - 3);
            vcount = 10'(m_ly + int'($urandom_range(0, 46)) - 3);
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                #1;
                check_eq("rst.pix_on", int'(pix_on), 0);
                check_eq("rst.pix_rgb", int'(pix_rgb), 0);
                check_eq("rst.rom_addr", int'(rom_addr), 0);
            end
            if (i == 1503) rst_n = 1'b1;
        end
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
